// File: rtl/ps2_tx_scheduler.sv
// ps2_tx_scheduler: round-robin arbiter feeding one byte per frame to the PS/2 transmitter,
// pacing issues by frame time plus inter-byte gap and holding off while the host inhibits.
module ps2_tx_scheduler #(
  parameter int FRAME_CYCLES = 55000,
  parameter int GAP_CYCLES   = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       src0_valid,
  input  logic [7:0] src0_data,
  output logic       src0_ready,
  input  logic       src1_valid,
  input  logic [7:0] src1_data,
  output logic       src1_ready,
  input  logic       inhibit,
  output logic       tx_rts,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       last_src
);
  localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);
  localparam logic [CW-1:0] STARTUP_LAST = CW'(FRAME_CYCLES + GAP_CYCLES - 1);
  localparam logic [CW-1:0] FRAME_LAST   = CW'(FRAME_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [2:0] {STARTUP, IDLE, ISSUE, FRAME, GAP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_req;
  logic          w_sel;
  assign w_req = !inhibit && (src0_valid || src1_valid);
  // on a tie the source not granted last time wins
  assign w_sel = (src0_valid && src1_valid) ? !last_src : src1_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= STARTUP;
      r_cnt      <= '0;
      src0_ready <= 1'b0;
      src1_ready <= 1'b0;
      tx_rts     <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b1;
      last_src   <= 1'b1;
    end else begin
      src0_ready <= 1'b0;
      src1_ready <= 1'b0;
      tx_rts     <= 1'b0;
      case (r_state)
        STARTUP:
          if (r_cnt == STARTUP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
        IDLE:
          if (w_req) begin
            r_state    <= ISSUE;
            busy       <= 1'b1;
            tx_data    <= w_sel ? src1_data : src0_data;
            src0_ready <= !w_sel;
            src1_ready <= w_sel;
            last_src   <= w_sel;
          end
        ISSUE: begin
          tx_rts  <= 1'b1;
          r_cnt   <= '0;
          r_state <= FRAME;
        end
        FRAME:
          if (r_cnt == FRAME_LAST) begin
            r_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end else r_state <= GAP;
          end else r_cnt <= r_cnt + 1'b1;
        GAP:
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            busy    <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= STARTUP;
      endcase
    end
endmodule
